can_reg_reader: RTL and testbench

Host-side read engine for the CAN controller register bank. It accepts single read requests, captures the addressed register from the flattened bank bus, and returns it with an acknowledge after a fixed latency. It issues clear-on-read strobes back to flagged registers (interrupt/status) and a pop strobe to the RX FIFO when its window address is read. It sits between the host bus adapter and the CAN register bank, alongside the existing write path.

---
 rtl/can_reg_pkg.sv | 21 ++
 rtl/can_reg_reader_if.sv | 32 +++
 rtl/can_register_asyn.sv | 28 ++
 rtl/can_reg_reader.sv | 151 +++++++++++++++
 tb/tb_can_reg_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_reg_pkg.sv
// ---------------------------------------------------------------------------
// can_reg_pkg
// Shared definitions for the CAN register bank read path.
//   state_t           : read engine state encoding (IDLE / FETCH / RESP)
//   INT_REG_ADDR      : address of the interrupt (clear-on-read) register
//   FIFO_WIN_ADDR     : address of the RX FIFO read window
//   CLR_MASK_DEFAULT  : default clear-on-read mask (interrupt register only)
// ---------------------------------------------------------------------------
package can_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int          INT_REG_ADDR     = 3;
  localparam int          FIFO_WIN_ADDR    = 16;
  localparam logic [31:0] CLR_MASK_DEFAULT = 32'h0000_0008;

endpackage : can_reg_pkg

// File: rtl/can_reg_reader_if.sv
// ---------------------------------------------------------------------------
// can_reg_reader_if
// Host-side read handshake between the bus adapter and the read engine.
//   rd_req  : read request (host -> engine)
//   rd_addr : read address (host -> engine)
//   rd_ack  : one-cycle completion pulse (engine -> host)
//   rd_data : read data, valid from rd_ack (engine -> host)
//   rd_err  : out-of-range flag, pulses with rd_ack (engine -> host)
// Modports: master = host adapter, slave = read engine.
// ---------------------------------------------------------------------------
interface can_reg_reader_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_err;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data, rd_err
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data, rd_err
  );

endinterface : can_reg_reader_if

// File: rtl/can_register_asyn.sv
// ---------------------------------------------------------------------------
// can_register_asyn
// Generic register with write enable and asynchronous active-high reset.
//   clk : clock
//   rst : asynchronous reset, active high, clears q to 0
//   we  : load enable
//   d   : data in
//   q   : registered data out
// ---------------------------------------------------------------------------
module can_register_asyn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule : can_register_asyn

// File: rtl/can_reg_reader.sv
// ---------------------------------------------------------------------------
// can_reg_reader
// Read engine for the CAN controller register bank. Accepts one read at a
// time, captures the addressed register from the flattened bank bus, and
// returns it with rd_ack two cycles after acceptance. Reads of flagged
// registers raise a one-hot clear strobe, and reads of the RX FIFO window
// raise a pop strobe, both coincident with rd_ack (after the data capture,
// so the host always sees the pre-clear value).
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   host      : read handshake (rd_req/rd_addr in, rd_ack/rd_data/rd_err out)
//   reg_bus   : register bank contents, register i at [i*WIDTH +: WIDTH]
//   clr_pulse : one-hot clear strobe to clear-on-read registers
//   fifo_pop  : RX FIFO pop strobe
// All outputs are registered.
// ---------------------------------------------------------------------------
module can_reg_reader
  import can_reg_pkg::*;
#(
  parameter int                  WIDTH     = 8,
  parameter int                  ADDR_W    = 5,
  parameter int                  NUM_REGS  = 32,
  parameter logic [NUM_REGS-1:0] CLR_MASK  = NUM_REGS'(CLR_MASK_DEFAULT),
  parameter int                  FIFO_ADDR = FIFO_WIN_ADDR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  can_reg_reader_if.slave           host,
  input  logic [NUM_REGS*WIDTH-1:0] reg_bus,
  output logic [NUM_REGS-1:0]       clr_pulse,
  output logic                      fifo_pop
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] FIFO_A     = ADDR_W'(FIFO_ADDR);
  // A window address beyond the implemented bank never pops.
  localparam bit                FIFO_IMPL  = (FIFO_ADDR < NUM_REGS);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                addr_load;
  logic                fetch_we;
  logic                addr_in_range;
  logic [WIDTH-1:0]    sel_data;
  logic [NUM_REGS-1:0] clr_onehot;

  logic                ack_nxt, err_nxt, pop_nxt;
  logic [NUM_REGS-1:0] clr_nxt;
  logic                ack_q, err_q, pop_q;
  logic [NUM_REGS-1:0] clr_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic                rst;

  assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_W);

  // Register select and clear strobe decode. An address with no matching
  // register leaves both at zero, which is exactly the out-of-range result.
  always_comb begin
    sel_data   = '0;
    clr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        sel_data      = reg_bus[i*WIDTH +: WIDTH];
        clr_onehot[i] = CLR_MASK[i];
      end
    end
  end

  // State and address latch.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (addr_load) begin
        addr_q <= host.rd_addr;
      end
    end
  end

  // Next state and next values of the registered response outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_nxt = state;
    addr_load = 1'b0;
    fetch_we  = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    clr_nxt   = '0;
    pop_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (host.rd_req) begin
          addr_load = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        fetch_we  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        ack_nxt   = 1'b1;
        err_nxt   = ~addr_in_range;
        clr_nxt   = clr_onehot;
        pop_nxt   = FIFO_IMPL && (addr_q == FIFO_A);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response strobes are registered so they rise on the edge leaving RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      clr_q <= '0;
      pop_q <= 1'b0;
    end else begin
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      clr_q <= clr_nxt;
      pop_q <= pop_nxt;
    end
  end

  // Read data holding register: loaded once at the FETCH edge, held until
  // the next accepted read reaches FETCH.
  assign rst = ~rst_n;

  can_register_asyn #(
    .WIDTH (WIDTH)
  ) u_rd_data (
    .clk (clk),
    .rst (rst),
    .we  (fetch_we),
    .d   (sel_data),
    .q   (rd_data_q)
  );

  assign host.rd_ack  = ack_q;
  assign host.rd_err  = err_q;
  assign host.rd_data = rd_data_q;
  assign clr_pulse    = clr_q;
  assign fifo_pop     = pop_q;

endmodule : can_reg_reader

// File: tb/tb_can_reg_reader.sv
// ---------------------------------------------------------------------------
// tb_can_reg_reader
// Self-checking bench for can_reg_reader with a 20-register bank so that
// addresses 20..31 are out of range. A transaction-level model predicts the
// outputs from request/acceptance timing; directed reads pin literal values.
// ---------------------------------------------------------------------------
module tb_can_reg_reader;

  localparam int                  WIDTH     = 8;
  localparam int                  ADDR_W    = 5;
  localparam int                  NUM_REGS  = 20;
  localparam int                  FIFO_ADDR = 16;
  localparam logic [NUM_REGS-1:0] CLR_MASK  = 20'h00208;

  localparam int M_PLAIN   = 0;
  localparam int M_CORRUPT = 1;
  localparam int M_BUSY    = 2;

  logic                      clk   = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REGS*WIDTH-1:0] reg_bus = '0;
  logic [NUM_REGS-1:0]       clr_pulse;
  logic                      fifo_pop;

  can_reg_reader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) hif ();

  can_reg_reader #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .CLR_MASK  (CLR_MASK),
    .FIFO_ADDR (FIFO_ADDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (hif),
    .reg_bus   (reg_bus),
    .clr_pulse (clr_pulse),
    .fifo_pop  (fifo_pop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void set_reg(input int i, input logic [WIDTH-1:0] v);
    reg_bus[i*WIDTH +: WIDTH] = v;
  endfunction

  // ---------------- transaction model ----------------
  // A read accepted at edge A has its data sampled at edge A+1 and its
  // response visible for the single cycle after edge A+2; a new request can
  // only be accepted once the previous response edge has passed.
  int                  edge_n   = 0;
  bit                  pend     = 1'b0;
  int                  acc_edge = 0;
  int                  m_addr   = 0;
  logic                m_ack    = 1'b0;
  logic                m_err    = 1'b0;
  logic                m_pop    = 1'b0;
  logic [WIDTH-1:0]    m_data   = '0;
  logic [NUM_REGS-1:0] m_clr    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   = 1'b0;
      edge_n = 0;
      m_ack  = 1'b0;
      m_err  = 1'b0;
      m_pop  = 1'b0;
      m_clr  = '0;
      m_data = '0;
    end else begin
      edge_n++;
      m_ack = 1'b0;
      m_err = 1'b0;
      m_pop = 1'b0;
      m_clr = '0;
      if (pend && edge_n == acc_edge + 1) begin
        if (m_addr < NUM_REGS) m_data = reg_bus[m_addr*WIDTH +: WIDTH];
        else                   m_data = '0;
      end
      if (pend && edge_n == acc_edge + 2) begin
        m_ack = 1'b1;
        m_err = (m_addr >= NUM_REGS);
        if (m_addr < NUM_REGS && CLR_MASK[m_addr]) m_clr[m_addr] = 1'b1;
        m_pop = (m_addr == FIFO_ADDR);
        pend  = 1'b0;
      end else if (!pend && hif.rd_req === 1'b1) begin
        pend     = 1'b1;
        acc_edge = edge_n;
        m_addr   = int'(hif.rd_addr);
      end
    end
  end

  // ---------------- compare + event counters ----------------
  bit cmp_en = 1'b0;
  int cyc    = 0;
  int n_ack  = 0;
  int n_pop  = 0;
  int n_clr  = 0;
  int ack_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (hif.rd_ack === 1'b1) begin
      n_ack++;
      ack_cyc.push_back(cyc);
    end
    if (fifo_pop === 1'b1) n_pop++;
    if (|clr_pulse) n_clr++;
    if (cmp_en) begin
      check("model rd_ack",    32'(hif.rd_ack),  32'(m_ack));
      check("model rd_data",   32'(hif.rd_data), 32'(m_data));
      check("model rd_err",    32'(hif.rd_err),  32'(m_err));
      check("model clr_pulse", 32'(clr_pulse),   32'(m_clr));
      check("model fifo_pop",  32'(fifo_pop),    32'(m_pop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_read(input  logic [ADDR_W-1:0] addr,
                         input  int                mode,
                         output int                lat,
                         output logic [WIDTH-1:0]  data,
                         output logic              err,
                         output logic [NUM_REGS-1:0] clr,
                         output logic              pop);
    tick();
    hif.rd_req  = 1'b1;
    hif.rd_addr = addr;
    tick();                                  // accepted; engine now fetching
    if (mode == M_BUSY) hif.rd_addr = addr ^ 5'h01;  // req held through FETCH
    else                hif.rd_req  = 1'b0;
    lat  = -1;
    data = '0;
    err  = 1'b0;
    clr  = '0;
    pop  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        hif.rd_req = 1'b0;
        if (mode == M_CORRUPT) set_reg(int'(addr), '0);
      end
      if (hif.rd_ack === 1'b1 && lat < 0) begin
        lat  = k;
        data = hif.rd_data;
        err  = hif.rd_err;
        clr  = clr_pulse;
        pop  = fifo_pop;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " rd_ack"},    32'(hif.rd_ack),  32'd0);
    check({tag, " rd_data"},   32'(hif.rd_data), 32'd0);
    check({tag, " rd_err"},    32'(hif.rd_err),  32'd0);
    check({tag, " clr_pulse"}, 32'(clr_pulse),   32'd0);
    check({tag, " fifo_pop"},  32'(fifo_pop),    32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int                  lat;
    int                  a0, p0, c0, t;
    logic [WIDTH-1:0]    data;
    logic                err, pop;
    logic [NUM_REGS-1:0] clr;

    hif.rd_req  = 1'b0;
    hif.rd_addr = '0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    cmp_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle: no activity for 10 cycles.
    a0 = n_ack;
    repeat (10) tick();
    check("idle no ack", 32'(n_ack - a0), 32'd0);

    // Plain read.
    set_reg(5, 8'hA5);
    set_reg(12, 8'h3C);
    set_reg(16, 8'h77);
    do_read(5'd5, M_PLAIN, lat, data, err, clr, pop);
    check("plain latency",   32'(lat),  32'd2);
    check("plain rd_data",   32'(data), 32'hA5);
    check("plain rd_err",    32'(err),  32'd0);
    check("plain clr_pulse", 32'(clr),  32'd0);
    check("plain fifo_pop",  32'(pop),  32'd0);
    check("plain data held", 32'(hif.rd_data), 32'hA5);

    // Clear-on-read, register cleared by the bank during RESP.
    set_reg(3, 8'h0C);
    do_read(5'd3, M_CORRUPT, lat, data, err, clr, pop);
    check("cor latency",   32'(lat),  32'd2);
    check("cor rd_data",   32'(data), 32'h0C);
    check("cor clr_pulse", 32'(clr),  32'h0000_0008);
    check("cor fifo_pop",  32'(pop),  32'd0);

    // Second clear-on-read register.
    set_reg(9, 8'h99);
    do_read(5'd9, M_PLAIN, lat, data, err, clr, pop);
    check("cor9 rd_data",   32'(data), 32'h99);
    check("cor9 clr_pulse", 32'(clr),  32'h0000_0200);

    // FIFO window with rd_req held: two acks 3 cycles apart.
    a0 = n_ack;
    p0 = n_pop;
    ack_cyc.delete();
    tick();
    hif.rd_req  = 1'b1;
    hif.rd_addr = 5'd16;
    t = 0;
    while (n_ack - a0 < 2 && t < 20) begin
      tick();
      t++;
    end
    hif.rd_req = 1'b0;
    check("fifo ack count", 32'(n_ack - a0), 32'd2);
    check("fifo pop count", 32'(n_pop - p0), 32'd2);
    if (ack_cyc.size() >= 2) check("fifo ack spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    else                     check("fifo ack spacing", 32'(ack_cyc.size()), 32'd2);
    check("fifo rd_data", 32'(hif.rd_data), 32'h77);
    repeat (6) tick();
    check("fifo no extra ack", 32'(n_ack - a0), 32'd2);

    // Out-of-range read with an extra request during FETCH.
    a0 = n_ack;
    do_read(5'd25, M_BUSY, lat, data, err, clr, pop);
    check("oor latency",   32'(lat),  32'd2);
    check("oor rd_data",   32'(data), 32'd0);
    check("oor rd_err",    32'(err),  32'd1);
    check("oor clr_pulse", 32'(clr),  32'd0);
    check("oor fifo_pop",  32'(pop),  32'd0);
    check("busy single ack", 32'(n_ack - a0), 32'd1);

    // Load nonzero data, then abort a clear-on-read read during FETCH.
    do_read(5'd12, M_PLAIN, lat, data, err, clr, pop);
    check("pre-abort rd_data", 32'(data), 32'h3C);
    set_reg(3, 8'h5A);
    a0 = n_ack;
    p0 = n_pop;
    c0 = n_clr;
    tick();
    hif.rd_req  = 1'b1;
    hif.rd_addr = 5'd3;
    tick();
    hif.rd_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("abort no ack", 32'(n_ack - a0), 32'd0);
    check("abort no clr", 32'(n_clr - c0), 32'd0);
    check("abort no pop", 32'(n_pop - p0), 32'd0);

    do_read(5'd5, M_PLAIN, lat, data, err, clr, pop);
    check("post-abort latency", 32'(lat),  32'd2);
    check("post-abort rd_data", 32'(data), 32'hA5);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_can_reg_reader
